dpram_arbiter: RTL and testbench

Round-robin arbiter that shares the 32x8 dual-port RAM among `NREQ` client requesters, with independent arbitration for the write port and the read port. It sits between the client blocks and the RAM's `wr_en`/`rd_en`/`wr_addr`/`rd_addr`/`w_data`/`r_data` pins. It registers every RAM-side command, tracks in-flight reads, and routes read data back to the requester that issued the read. It also stalls a read that targets the address being written in the same cycle.

---
 rtl/dpram_arbiter.sv | 138 +++++++++++++
 tb/tb_dpram_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dpram_arbiter
// Purpose  : Round-robin write/read arbitration onto a shared dual-port RAM,
//            with same-address read stall and tagged read-data return.
// Revision : 1.0  initial release
// ============================================================================
module dpram_arbiter #(
    parameter int NREQ   = 4,
    parameter int AW     = 5,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_wr,
    input  logic [NREQ*AW-1:0] req_wr_addr,
    input  logic [NREQ*DW-1:0] req_wr_data,
    output logic [NREQ-1:0]    gnt_wr,
    input  logic [NREQ-1:0]    req_rd,
    input  logic [NREQ*AW-1:0] req_rd_addr,
    output logic [NREQ-1:0]    gnt_rd,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic               wr_en,
    output logic [AW-1:0]      wr_addr,
    output logic [DW-1:0]      w_data,
    output logic               rd_en,
    output logic [AW-1:0]      rd_addr,
    input  logic [DW-1:0]      r_data
);

    localparam int c_ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic              r_run;
    logic [c_ID_W-1:0] r_wptr;
    logic [c_ID_W-1:0] r_rptr;
    logic [RD_LAT:0]   r_tag_vld;
    logic [c_ID_W-1:0] r_tag_id [RD_LAT+1];

    logic [c_ID_W:0]   w_wr_pick;
    logic [c_ID_W:0]   w_rd_pick;
    logic [c_ID_W-1:0] w_wr_win;
    logic [c_ID_W-1:0] w_rd_win;
    logic [AW-1:0]     w_wr_addr;
    logic [DW-1:0]     w_wr_data;
    logic [AW-1:0]     w_rd_addr;
    logic              w_arb_en;
    logic              w_hazard;
    logic              w_wr_go;
    logic              w_rd_go;

    // Returns {found, index} of the first requester at or after ptr, cyclically.
    function automatic logic [c_ID_W:0] f_pick(input logic [NREQ-1:0] req,
                                               input logic [c_ID_W-1:0] ptr);
        logic [c_ID_W:0] v_pick;
        int              v_best;
        int              v_dist;
        v_pick = '0;
        v_best = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            v_dist = (i + NREQ - int'(ptr)) % NREQ;
            if (req[i] && (v_dist < v_best)) begin
                v_best = v_dist;
                v_pick = {1'b1, c_ID_W'(i)};
            end
        end
        return v_pick;
    endfunction

    function automatic logic [c_ID_W-1:0] f_next(input logic [c_ID_W-1:0] idx);
        return (int'(idx) == NREQ - 1) ? '0 : idx + c_ID_W'(1);
    endfunction

    assign w_wr_pick = f_pick(req_wr, r_wptr);
    assign w_rd_pick = f_pick(req_rd, r_rptr);
    assign w_wr_win  = w_wr_pick[c_ID_W-1:0];
    assign w_rd_win  = w_rd_pick[c_ID_W-1:0];
    assign w_wr_addr = req_wr_addr[int'(w_wr_win)*AW +: AW];
    assign w_wr_data = req_wr_data[int'(w_wr_win)*DW +: DW];
    assign w_rd_addr = req_rd_addr[int'(w_rd_win)*AW +: AW];

    // r_run keeps grants off for the whole first cycle after a sampled reset.
    assign w_arb_en = rst & r_run;
    assign w_hazard = w_wr_pick[c_ID_W] & w_rd_pick[c_ID_W] & (w_wr_addr == w_rd_addr);
    assign w_wr_go  = w_arb_en & w_wr_pick[c_ID_W];
    assign w_rd_go  = w_arb_en & w_rd_pick[c_ID_W] & ~w_hazard;

    assign gnt_wr    = w_wr_go ? (NREQ'(1) << w_wr_win) : '0;
    assign gnt_rd    = w_rd_go ? (NREQ'(1) << w_rd_win) : '0;
    assign rsp_valid = (rst & r_tag_vld[RD_LAT]) ? (NREQ'(1) << r_tag_id[RD_LAT]) : '0;
    assign rsp_data  = r_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_run   <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            w_data  <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
        end else begin
            r_run <= 1'b1;
            wr_en <= w_wr_go;
            rd_en <= w_rd_go;
            if (w_wr_go) begin
                wr_addr <= w_wr_addr;
                w_data  <= w_wr_data;
                r_wptr  <= f_next(w_wr_win);
            end
            if (w_rd_go) begin
                rd_addr <= w_rd_addr;
                r_rptr  <= f_next(w_rd_win);
            end
        end
    end

    // Stage 0 lines up with rd_en at the RAM pin; the last stage with r_data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tag_vld <= '0;
            for (int k = 0; k <= RD_LAT; k++) begin
                r_tag_id[k] <= '0;
            end
        end else begin
            r_tag_vld[0] <= w_rd_go;
            r_tag_id[0]  <= w_rd_win;
            for (int k = 1; k <= RD_LAT; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_id[k]  <= r_tag_id[k-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dpram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpram_arbiter
// Purpose  : Directed plus randomized self-checking bench for dpram_arbiter
//            against a transaction-level reference model and a RAM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dpram_arbiter;

    localparam int NREQ   = 4;
    localparam int AW     = 5;
    localparam int DW     = 8;
    localparam int RD_LAT = 1;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_wr;
    logic [NREQ*AW-1:0] req_wr_addr;
    logic [NREQ*DW-1:0] req_wr_data;
    logic [NREQ-1:0]    gnt_wr;
    logic [NREQ-1:0]    req_rd;
    logic [NREQ*AW-1:0] req_rd_addr;
    logic [NREQ-1:0]    gnt_rd;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      w_data;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic [DW-1:0]      r_data;

    always #5 clk = ~clk;

    dpram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req_wr      (req_wr),
        .req_wr_addr (req_wr_addr),
        .req_wr_data (req_wr_data),
        .gnt_wr      (gnt_wr),
        .req_rd      (req_rd),
        .req_rd_addr (req_rd_addr),
        .gnt_rd      (gnt_rd),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .w_data      (w_data),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .r_data      (r_data)
    );

    // 32x8 dual-port RAM with one cycle of read latency.
    logic [DW-1:0] ram [32];
    always @(posedge clk) begin
        if (wr_en) ram[wr_addr] <= w_data;
        if (rd_en) r_data <= ram[rd_addr];
    end

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    int            errors = 0;
    int            checks = 0;
    int            cyc    = 0;
    int            m_wptr = 0;
    int            m_rptr = 0;
    bit            m_run  = 1'b0;
    int            p_wr   = -1;
    int            p_rd   = -1;
    bit            e_wr_en;
    logic [AW-1:0] e_wr_addr;
    logic [DW-1:0] e_w_data;
    bit            e_rd_en;
    logic [AW-1:0] e_rd_addr;
    logic [DW-1:0] m_mem [32];
    rsp_t          m_q [$];
    logic [3:0]    fair_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    function automatic logic [AW-1:0] wa(int i);
        return req_wr_addr[i*AW +: AW];
    endfunction
    function automatic logic [DW-1:0] wd(int i);
        return req_wr_data[i*DW +: DW];
    endfunction
    function automatic logic [AW-1:0] ra(int i);
        return req_rd_addr[i*AW +: AW];
    endfunction
    function automatic logic [NREQ-1:0] oh(int p);
        return (p < 0) ? '0 : (NREQ'(1) << p);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // First requester at or after the pointer wins; a read to the write winner's address waits.
    task automatic predict();
        p_wr = -1;
        p_rd = -1;
        if (rst && m_run) begin
            for (int k = 0; k < NREQ; k++) begin
                if (p_wr < 0 && req_wr[(m_wptr + k) % NREQ]) p_wr = (m_wptr + k) % NREQ;
                if (p_rd < 0 && req_rd[(m_rptr + k) % NREQ]) p_rd = (m_rptr + k) % NREQ;
            end
            if (p_wr >= 0 && p_rd >= 0 && wa(p_wr) == ra(p_rd)) p_rd = -1;
        end
    endtask

    task automatic check_model();
        logic [NREQ-1:0] exp_v;
        logic [DW-1:0]   exp_d;
        exp_v = '0;
        exp_d = '0;
        if (rst && m_q.size() > 0 && m_q[0].due == cyc) begin
            exp_v = oh(m_q[0].id);
            exp_d = m_q[0].data;
        end
        chk("gnt_wr", gnt_wr, oh(p_wr));
        chk("gnt_rd", gnt_rd, oh(p_rd));
        chk("wr_en", wr_en, e_wr_en);
        chk("wr_addr", wr_addr, e_wr_addr);
        chk("w_data", w_data, e_w_data);
        chk("rd_en", rd_en, e_rd_en);
        chk("rd_addr", rd_addr, e_rd_addr);
        chk("rsp_valid", rsp_valid, exp_v);
        if (exp_v != '0) chk("rsp_data", rsp_data, exp_d);
    endtask

    task automatic advance();
        if (m_q.size() > 0 && m_q[0].due == cyc) void'(m_q.pop_front());
        if (!rst) begin
            m_wptr = 0;  m_rptr = 0;  m_run = 1'b0;
            e_wr_en = 1'b0;  e_wr_addr = '0;  e_w_data = '0;
            e_rd_en = 1'b0;  e_rd_addr = '0;
            m_q.delete();
        end else begin
            m_run   = 1'b1;
            e_wr_en = (p_wr >= 0);
            e_rd_en = (p_rd >= 0);
            if (p_rd >= 0) begin
                e_rd_addr = ra(p_rd);
                m_q.push_back('{due: cyc + 1 + RD_LAT, id: p_rd, data: m_mem[ra(p_rd)]});
                m_rptr = (p_rd + 1) % NREQ;
            end
            if (p_wr >= 0) begin
                e_wr_addr = wa(p_wr);
                e_w_data  = wd(p_wr);
                m_mem[wa(p_wr)] = wd(p_wr);
                m_wptr = (p_wr + 1) % NREQ;
            end
        end
        cyc++;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic tick();
        predict();
        check_model();
        @(posedge clk);
        advance();
        #1;
    endtask

    task automatic set_wr(int i, int a, int d);
        req_wr[i] = 1'b1;
        req_wr_addr[i*AW +: AW] = AW'(a);
        req_wr_data[i*DW +: DW] = DW'(d);
    endtask

    task automatic set_rd(int i, int a);
        req_rd[i] = 1'b1;
        req_rd_addr[i*AW +: AW] = AW'(a);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 32; i++) begin
            ram[i]   = '0;
            m_mem[i] = '0;
        end
        r_data      = '0;
        rst         = 1'b0;
        req_wr      = '0;
        req_rd      = '0;
        req_wr_addr = '0;
        req_wr_data = '0;
        req_rd_addr = '0;
        @(posedge clk);
        advance();
        #1;

        // Reset state
        settle();
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 4'b0000);
        tick();

        // Round-robin fairness from reset release
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) set_wr(i, 8 + i, 8'h80 + i);
        settle();
        chk("holdoff_gnt_wr", gnt_wr, 4'b0000);
        tick();
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("fair_gnt_wr", gnt_wr, fair_seq[k]);
            if (k >= 1) chk("fair_wr_en", wr_en, 1'b1);
            tick();
        end
        req_wr = '0;
        settle(); tick();

        // Write then read
        set_wr(0, 5, 8'hA5);
        settle();
        chk("wr_gnt", gnt_wr, 4'b0001);
        tick();
        req_wr[0] = 1'b0;
        settle();
        chk("wr_en_n1", wr_en, 1'b1);
        chk("wr_addr_n1", wr_addr, 5);
        chk("w_data_n1", w_data, 8'hA5);
        tick();
        set_rd(2, 5);
        settle();
        chk("rd_gnt", gnt_rd, 4'b0100);
        tick();
        req_rd[2] = 1'b0;
        settle(); tick();
        settle();
        chk("rd_rsp_valid", rsp_valid, 4'b0100);
        chk("rd_rsp_data", rsp_data, 8'hA5);
        tick();

        // Same-address hazard
        set_wr(1, 7, 8'h3C);
        set_rd(3, 7);
        settle();
        chk("haz_gnt_wr", gnt_wr, 4'b0010);
        chk("haz_gnt_rd", gnt_rd, 4'b0000);
        tick();
        req_wr[1] = 1'b0;
        settle();
        chk("haz_gnt_rd_n1", gnt_rd, 4'b1000);
        tick();
        req_rd[3] = 1'b0;
        settle(); tick();
        settle();
        chk("haz_rsp_valid", rsp_valid, 4'b1000);
        chk("haz_rsp_data", rsp_data, 8'h3C);
        tick();

        // Parallel write and read to different addresses
        set_wr(0, 1, 8'h5A);
        set_rd(1, 2);
        settle();
        chk("par_gnt_wr", gnt_wr, 4'b0001);
        chk("par_gnt_rd", gnt_rd, 4'b0010);
        tick();
        req_wr[0] = 1'b0;
        req_rd[1] = 1'b0;
        settle();
        chk("par_wr_en", wr_en, 1'b1);
        chk("par_rd_en", rd_en, 1'b1);
        tick();

        // Back-to-back reads
        set_wr(0, 3, 8'h11);
        settle(); tick();
        req_wr[0] = 1'b0;
        set_wr(1, 4, 8'h22);
        settle(); tick();
        req_wr[1] = 1'b0;
        settle(); tick();
        set_rd(0, 3);
        settle();
        chk("b2b_gnt0", gnt_rd, 4'b0001);
        tick();
        req_rd[0] = 1'b0;
        set_rd(2, 4);
        settle();
        chk("b2b_gnt2", gnt_rd, 4'b0100);
        tick();
        req_rd[2] = 1'b0;
        settle();
        chk("b2b_rsp0_valid", rsp_valid, 4'b0001);
        chk("b2b_rsp0_data", rsp_data, 8'h11);
        tick();
        settle();
        chk("b2b_rsp2_valid", rsp_valid, 4'b0100);
        chk("b2b_rsp2_data", rsp_data, 8'h22);
        tick();

        // Reset while a read is in flight
        set_rd(1, 3);
        settle();
        chk("rmr_gnt", gnt_rd, 4'b0010);
        tick();
        req_rd[1] = 1'b0;
        rst = 1'b0;
        settle();
        chk("rmr_rsp_n1", rsp_valid, 4'b0000);
        tick();
        for (int i = 0; i < NREQ; i++) set_rd(i, 16 + i);
        settle();
        chk("rmr_rsp_n2", rsp_valid, 4'b0000);
        chk("rmr_wr_en", wr_en, 1'b0);
        chk("rmr_rd_en", rd_en, 1'b0);
        chk("rmr_wr_addr", wr_addr, 0);
        chk("rmr_rd_addr", rd_addr, 0);
        chk("rmr_w_data", w_data, 0);
        chk("rmr_gnt_low", gnt_rd, 4'b0000);
        tick();
        rst = 1'b1;
        settle();
        chk("rmr_holdoff", gnt_rd, 4'b0000);
        tick();
        settle();
        chk("rmr_first_gnt", gnt_rd, 4'b0001);
        tick();

        // Randomized traffic; requesters hold until granted, addresses clustered to provoke hazards
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (p_wr == i) req_wr[i] = 1'b0;
                if (p_rd == i) req_rd[i] = 1'b0;
                if (!req_wr[i] && $urandom_range(0, 99) < 40)
                    set_wr(i, $urandom_range(0, 7), $urandom_range(0, 255));
                if (!req_rd[i] && $urandom_range(0, 99) < 40)
                    set_rd(i, $urandom_range(0, 7));
            end
            rst = ($urandom_range(0, 59) != 0);
            settle();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
